// File: rtl/ddr3_burst_arbiter.sv
// ddr3_burst_arbiter
//   Round-robin arbiter placing CH_NUM write ports and CH_NUM read ports onto a
//   single DDR3 controller command/data interface. Each channel owns a linear
//   burst pointer per direction that wraps within that channel's address region.
//   Controller beat acks (data_ack) are steered back to the granted FIFO.
//
//   Optional feature macro: DDR3_PINGPONG_EN
//     defined   : each channel region is split into two halves; writes fill one
//                 half while reads drain the other (bank swap on pointer wrap).
//     undefined : one region per channel, shared by reads and writes.
//
//   Handshake: the command is offered with cmd_valid and held, together with
//   cmd_rd and cmd_addr, unchanged until the cycle in which cmd_valid and
//   cmd_ready are both high; that cycle transfers the command.
module ddr3_burst_arbiter #(
    parameter int CH_NUM      = 2,
    parameter int ADDR_WD     = 28,
    parameter int BURST_LEN   = 64,
    parameter int ADDR_STEP   = 8,
    parameter int REGION_SIZE = 2**20
) (
    input  logic                clk_ref,
    input  logic                rst_n,
    input  logic                ddr3_init_done,
    input  logic [CH_NUM-1:0]   wr_req,
    input  logic [CH_NUM-1:0]   rd_req,
    input  logic [CH_NUM-1:0]   wr_load,
    input  logic [CH_NUM-1:0]   rd_load,
    output logic                cmd_valid,
    output logic                cmd_rd,
    output logic [ADDR_WD-1:0]  cmd_addr,
    input  logic                cmd_ready,
    input  logic                data_ack,
    output logic [CH_NUM-1:0]   wr_ack,
    output logic [CH_NUM-1:0]   rd_ack,
    output logic                busy,
    output logic [2:0]          dbg_state
);

    localparam int SLOT_NUM    = 2 * CH_NUM;
    localparam int SLOT_WD     = $clog2(SLOT_NUM);
    localparam int CH_WD       = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam int PTR_WD      = $clog2(REGION_SIZE);
    localparam int BEAT_WD     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int BURST_BYTES = BURST_LEN * ADDR_STEP;
`ifdef DDR3_PINGPONG_EN
    localparam int PTR_LIMIT   = REGION_SIZE / 2;
`else
    localparam int PTR_LIMIT   = REGION_SIZE;
`endif
    localparam logic [ADDR_WD-1:0] REGION_A  = ADDR_WD'(REGION_SIZE);
    localparam logic [BEAT_WD-1:0] LAST_BEAT = BEAT_WD'(BURST_LEN - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARB  = 3'd1,
        ST_CMD  = 3'd2,
        ST_DATA = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [SLOT_NUM-1:0]  snap_q, snap_d;
    logic [SLOT_WD-1:0]   slot_q, slot_d;
    logic [SLOT_WD-1:0]   rr_q, rr_d;
    logic [ADDR_WD-1:0]   addr_q, addr_d;
    logic [BEAT_WD-1:0]   beat_q, beat_d;

    logic [PTR_WD-1:0]    wr_ptr_q [CH_NUM];
    logic [PTR_WD-1:0]    wr_ptr_d [CH_NUM];
    logic [PTR_WD-1:0]    rd_ptr_q [CH_NUM];
    logic [PTR_WD-1:0]    rd_ptr_d [CH_NUM];
    logic [CH_NUM-1:0]    wr_pend_q, wr_pend_d;
    logic [CH_NUM-1:0]    rd_pend_q, rd_pend_d;
`ifdef DDR3_PINGPONG_EN
    logic [CH_NUM-1:0]    wr_bank_q, wr_bank_d;
    logic [CH_NUM-1:0]    rd_bank_q, rd_bank_d;
`endif

    logic [SLOT_NUM-1:0]  req_vec;
    logic [SLOT_WD-1:0]   win_slot;
    logic                 win_found;
    logic [SLOT_WD:0]     idx_w;
    logic [CH_WD-1:0]     win_ch;
    logic [PTR_WD-1:0]    win_ptr;
    logic [ADDR_WD-1:0]   win_addr;

    // Advance a burst pointer by one burst; MSB of the result flags a region wrap.
    function automatic logic [PTR_WD:0] next_ptr(input logic [PTR_WD-1:0] p);
        logic [PTR_WD:0] sum;
        sum = {1'b0, p} + (PTR_WD+1)'(BURST_BYTES);
        if (sum == (PTR_WD+1)'(PTR_LIMIT)) begin
            next_ptr = {1'b1, {PTR_WD{1'b0}}};
        end else begin
            next_ptr = {1'b0, sum[PTR_WD-1:0]};
        end
    endfunction

    // Interleave requests into slot order: even slot = write, odd slot = read.
    always_comb begin
        req_vec = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            req_vec[2*i]   = wr_req[i];
            req_vec[2*i+1] = rd_req[i];
        end
    end

    // Round-robin search over the snapshot, starting at the slot after the last winner.
    always_comb begin
        win_found = 1'b0;
        win_slot  = '0;
        idx_w     = '0;
        for (int off = 0; off < SLOT_NUM; off++) begin
            idx_w = {1'b0, rr_q} + (SLOT_WD+1)'(off);
            if (idx_w >= (SLOT_WD+1)'(SLOT_NUM)) begin
                idx_w = idx_w - (SLOT_WD+1)'(SLOT_NUM);
            end
            if (!win_found && snap_q[idx_w[SLOT_WD-1:0]]) begin
                win_found = 1'b1;
                win_slot  = idx_w[SLOT_WD-1:0];
            end
        end
    end

    // Burst start address of the winning slot, taken from its current pointer.
    always_comb begin
        win_ch   = CH_WD'(win_slot >> 1);
        win_ptr  = win_slot[0] ? rd_ptr_q[win_ch] : wr_ptr_q[win_ch];
        win_addr = ADDR_WD'(win_ch) * REGION_A + ADDR_WD'(win_ptr);
`ifdef DDR3_PINGPONG_EN
        if (win_slot[0] ? rd_bank_q[win_ch] : wr_bank_q[win_ch]) begin
            win_addr = win_addr + ADDR_WD'(REGION_SIZE / 2);
        end
`endif
    end

    // Next-state logic for the grant FSM and its per-burst registers.
    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        slot_d  = slot_q;
        rr_d    = rr_q;
        addr_d  = addr_q;
        beat_d  = beat_q;
        unique case (state_q)
            ST_IDLE: begin
                if (ddr3_init_done && (|req_vec)) begin
                    snap_d  = req_vec;
                    state_d = ST_ARB;
                end
            end
            ST_ARB: begin
                slot_d  = win_slot;
                addr_d  = win_addr;
                rr_d    = (win_slot == SLOT_WD'(SLOT_NUM - 1)) ? '0 : win_slot + 1'b1;
                state_d = ST_CMD;
            end
            ST_CMD: begin
                if (cmd_ready) begin
                    beat_d  = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (data_ack) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d = ST_DONE;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pointer, pending-clear and bank updates: a load always wins, a load seen
    // during the channel's own burst keeps the DONE increment from reviving it.
    always_comb begin
        wr_pend_d = wr_pend_q;
        rd_pend_d = rd_pend_q;
`ifdef DDR3_PINGPONG_EN
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
`endif
        for (int i = 0; i < CH_NUM; i++) begin
            logic wr_fly, rd_fly, wr_done, rd_done;
            logic [PTR_WD:0] wr_nx, rd_nx;
            wr_ptr_d[i] = wr_ptr_q[i];
            rd_ptr_d[i] = rd_ptr_q[i];
            wr_fly  = ((state_q == ST_ARB) && (win_slot == SLOT_WD'(2*i))) ||
                      ((state_q inside {ST_CMD, ST_DATA}) && (slot_q == SLOT_WD'(2*i)));
            rd_fly  = ((state_q == ST_ARB) && (win_slot == SLOT_WD'(2*i+1))) ||
                      ((state_q inside {ST_CMD, ST_DATA}) && (slot_q == SLOT_WD'(2*i+1)));
            wr_done = (state_q == ST_DONE) && (slot_q == SLOT_WD'(2*i));
            rd_done = (state_q == ST_DONE) && (slot_q == SLOT_WD'(2*i+1));
            wr_nx   = next_ptr(wr_ptr_q[i]);
            rd_nx   = next_ptr(rd_ptr_q[i]);

            if (wr_fly && wr_load[i]) begin
                wr_pend_d[i] = 1'b1;
            end
            if (wr_done) begin
                wr_pend_d[i] = 1'b0;
            end
            if (wr_load[i]) begin
                wr_ptr_d[i] = '0;
`ifdef DDR3_PINGPONG_EN
                wr_bank_d[i] = 1'b0;
`endif
            end else if (wr_done && !wr_pend_q[i]) begin
                wr_ptr_d[i] = wr_nx[PTR_WD-1:0];
`ifdef DDR3_PINGPONG_EN
                if (wr_nx[PTR_WD]) begin
                    wr_bank_d[i] = ~wr_bank_q[i];
                end
`endif
            end

            if (rd_fly && rd_load[i]) begin
                rd_pend_d[i] = 1'b1;
            end
            if (rd_done) begin
                rd_pend_d[i] = 1'b0;
            end
            if (rd_load[i]) begin
                rd_ptr_d[i] = '0;
`ifdef DDR3_PINGPONG_EN
                rd_bank_d[i] = ~wr_bank_q[i];
`endif
            end else if (rd_done && !rd_pend_q[i]) begin
                rd_ptr_d[i] = rd_nx[PTR_WD-1:0];
`ifdef DDR3_PINGPONG_EN
                if (rd_nx[PTR_WD]) begin
                    rd_bank_d[i] = ~wr_bank_q[i];
                end
`endif
            end
        end
    end

    // Command outputs and beat-ack steering to the granted FIFO only.
    always_comb begin
        cmd_valid = (state_q == ST_CMD);
        cmd_rd    = cmd_valid & slot_q[0];
        cmd_addr  = cmd_valid ? addr_q : '0;
        busy      = (state_q != ST_IDLE);
        dbg_state = state_q;
        wr_ack    = '0;
        rd_ack    = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            wr_ack[i] = (state_q == ST_DATA) && data_ack && (slot_q == SLOT_WD'(2*i));
            rd_ack[i] = (state_q == ST_DATA) && data_ack && (slot_q == SLOT_WD'(2*i+1));
        end
    end

    // FSM and burst-context registers.
    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            snap_q  <= '0;
            slot_q  <= '0;
            rr_q    <= '0;
            addr_q  <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            slot_q  <= slot_d;
            rr_q    <= rr_d;
            addr_q  <= addr_d;
            beat_q  <= beat_d;
        end
    end

    // Per-channel pointer state.
    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CH_NUM; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
            end
            wr_pend_q <= '0;
            rd_pend_q <= '0;
`ifdef DDR3_PINGPONG_EN
            wr_bank_q <= '0;
            rd_bank_q <= '0;
`endif
        end else begin
            for (int i = 0; i < CH_NUM; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
            end
            wr_pend_q <= wr_pend_d;
            rd_pend_q <= rd_pend_d;
`ifdef DDR3_PINGPONG_EN
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
`endif
        end
    end

endmodule
